sn74f401: RTL and testbench



---
 rtl/sn74f401.sv | 65 ++++++
 tb/tb_sn74f401.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sn74f401.sv
// Serial CRC generator/checker with a 16-bit register and eight selectable polynomials.
// Data mode divides the serial stream by the polynomial; check-word mode shifts the remainder out on q.
module sn74f401 #(
  parameter int tPD_min = 0,
  parameter int tPD_typ = 15,
  parameter int tPD_max = 25
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       pre,
  input  logic       ce,
  input  logic       cwe,
  input  logic [2:0] s,
  input  logic       d,
  output logic       q,
  output logic       er
);

  // The delays only matter to timing-annotated simulation; here they are just sanity-checked.
  if (tPD_min > tPD_typ || tPD_typ > tPD_max) begin : g_tpd_check
    $error("sn74f401: expected tPD_min <= tPD_typ <= tPD_max");
  end

  typedef struct packed {
    logic [15:0] poly;  // low n bits of the generator polynomial
    logic [15:0] mask;  // ones in r[n-1:0]
    logic [15:0] top;   // one-hot r[n-1]
  } poly_t;

  poly_t       p;
  logic [15:0] r, r_nxt, shl;
  logic        msb, fb;

  always_comb begin
    p = '{16'h8005, 16'hFFFF, 16'h8000};
    unique case (s)
      3'd0: p = '{16'h8005, 16'hFFFF, 16'h8000};
      3'd1: p = '{16'h4003, 16'hFFFF, 16'h8000};
      3'd2: p = '{16'hA097, 16'hFFFF, 16'h8000};
      3'd3: p = '{16'h080F, 16'h0FFF, 16'h0800};
      3'd4: p = '{16'h00B3, 16'h00FF, 16'h0080};
      3'd5: p = '{16'h0001, 16'h00FF, 16'h0080};
      3'd6: p = '{16'h1021, 16'hFFFF, 16'h8000};
      3'd7: p = '{16'h0811, 16'hFFFF, 16'h8000};
    endcase
  end

  // Masking every update keeps r[15:n] at zero even when s shrinks the degree mid-frame.
  always_comb begin
    msb   = |(r & p.top);
    fb    = d ^ msb;
    shl   = {r[14:0], 1'b0};
    r_nxt = cwe ? ((shl ^ (fb ? p.poly : 16'h0000)) & p.mask) : (shl & p.mask);
  end

  always_ff @(posedge clk) begin
    if (clr)      r <= 16'h0000;
    else if (pre) r <= p.mask;
    else if (ce)  r <= r_nxt;
  end

  assign q  = msb;
  assign er = |(r & p.mask);

endmodule

// File: tb/tb_sn74f401.sv
// Self-checking bench for sn74f401: vector table, hand-written frame sequences, and a
// randomized run against an arithmetic reference model of the CRC register.
module tb_sn74f401;
  logic       clk = 1'b0;
  logic       clr, pre, ce, cwe, d;
  logic [2:0] s;
  logic       q, er;

  int total = 0;
  int bad   = 0;

  sn74f401 dut (.clk(clk), .clr(clr), .pre(pre), .ce(ce), .cwe(cwe), .s(s), .d(d), .q(q), .er(er));

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, pre, ce, cwe;
    logic [2:0] s;
    logic       d;
    logic       eq, eer;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic p, logic e, logic w, logic [2:0] sel, logic dd,
                              logic eq, logic eer);
    vec_t v;
    v.clr = c; v.pre = p; v.ce = e; v.cwe = w; v.s = sel; v.d = dd; v.eq = eq; v.eer = eer;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic p, input logic e, input logic w,
                       input logic [2:0] sel, input logic dd);
    clr = c; pre = p; ce = e; cwe = w; s = sel; d = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr(input logic [2:0] sel);
    drive(1, 0, 1, 1, sel, 0);
    tick();
  endtask

  task automatic shift_bits(input logic [31:0] v, input int nb, input logic [2:0] sel);
    for (int i = nb - 1; i >= 0; i--) begin
      drive(0, 0, 1, 1, sel, v[i]);
      tick();
    end
  endtask

  // Shift the register out in check-word mode, collecting q MSB first.
  task automatic read_word(input int nb, input logic [2:0] sel, output logic [15:0] w);
    w = 16'h0;
    for (int i = 0; i < nb; i++) begin
      drive(0, 0, 1, 0, sel, 1'($urandom));
      #1;
      w = {w[14:0], q};
      tick();
    end
  endtask

  // Reference model: polynomial table as plain numbers, register as an int.
  int unsigned m_poly[8] = '{32'h8005, 32'h4003, 32'hA097, 32'h080F, 32'h00B3, 32'h0001, 32'h1021, 32'h0811};
  int          m_deg[8]  = '{16, 16, 16, 12, 8, 8, 16, 16};
  int unsigned m_r;

  function automatic int unsigned m_mask(int n);
    return (32'd1 << n) - 1;
  endfunction

  task automatic model_step(input logic c, input logic p, input logic e, input logic w,
                            input logic [2:0] sel, input logic dd);
    int          n;
    int unsigned top;
    n   = m_deg[sel];
    top = (m_r >> (n - 1)) & 1;
    if (c)        m_r = 0;
    else if (p)   m_r = m_mask(n);
    else if (e) begin
      if (w && ((top ^ dd) != 0)) m_r = ((m_r << 1) ^ m_poly[sel]) & m_mask(n);
      else                        m_r = (m_r << 1) & m_mask(n);
    end
  endtask

  logic [15:0] w16;
  logic [15:0] tmp;

  initial begin
    drive(0, 0, 0, 0, 0, 0);

    // Vector table: reset, byte 0x01 under CRC-16, check-word shift-out, preset/clear priority.
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
    for (int i = 7; i >= 0; i--) begin
      tmp = 16'h0001;
      vecs.push_back(mk(0, 0, 1, 1, 0, tmp[i], (i == 0), (i == 0)));
    end
    for (int k = 1; k <= 16; k++) begin
      tmp = 16'h8005 << k;
      vecs.push_back(mk(0, 0, 1, 0, 0, 1'($urandom), tmp[15], (k < 16)));
    end
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0, 1, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].pre, vecs[i].ce, vecs[i].cwe, vecs[i].s, vecs[i].d);
      tick();
      check($sformatf("vec%0d_q", i), 16'(q), 16'(vecs[i].eq));
      check($sformatf("vec%0d_er", i), 16'(er), 16'(vecs[i].eer));
    end

    // Receiver: data followed by its check word leaves a zero remainder.
    do_clr(0);
    shift_bits(32'h018005, 24, 0);
    check("rx_good_er", 16'(er), 16'h0);
    do_clr(0);
    shift_bits(32'h018005 ^ 32'h000400, 24, 0);
    check("rx_flip_er", 16'(er), 16'h1);

    // CCITT and CRC-12 remainders of byte 0x01.
    do_clr(6);
    shift_bits(32'h01, 8, 6);
    read_word(16, 6, w16);
    check("ccitt_r", w16, 16'h1021);
    do_clr(3);
    shift_bits(32'h01, 8, 3);
    check("crc12_q", 16'(q), 16'h1);
    read_word(16, 0, w16);
    check("crc12_r_full", w16, 16'h080F);

    // LRC-8: a byte XORed with itself clears.
    do_clr(5);
    shift_bits(32'hA5, 8, 5);
    check("lrc_er1", 16'(er), 16'h1);
    shift_bits(32'hA5, 8, 5);
    check("lrc_er0", 16'(er), 16'h0);
    do_clr(5);
    shift_bits(32'hA5, 8, 5);
    read_word(8, 5, w16);
    check("lrc_r", w16, 16'h00A5);

    // Preset loads all ones; ce=0 holds through toggling d.
    drive(0, 1, 0, 1, 0, 0);
    tick();
    read_word(16, 0, w16);
    check("pre_r", w16, 16'hFFFF);
    do_clr(0);
    shift_bits(32'h01, 8, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, i[0], 0, ~i[0]);
      tick();
    end
    read_word(16, 0, w16);
    check("hold_r", w16, 16'h8005);

    // Clear mid-frame leaves no residue.
    do_clr(6);
    shift_bits(32'hB, 4, 6);
    do_clr(6);
    check("midclr_er", 16'(er), 16'h0);
    shift_bits(32'h01, 8, 6);
    read_word(16, 6, w16);
    check("midclr_r", w16, 16'h1021);

    // Randomized run against the reference model.
    do_clr(0);
    m_r = 0;
    begin
      logic [2:0] sel;
      logic       rc, rp, re, rw, rd;
      int         n;
      sel = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(15) == 0) sel = 3'($urandom);
        rc = ($urandom_range(63) == 0);
        rp = ($urandom_range(63) == 0);
        re = ($urandom_range(7) != 0);
        rw = ($urandom_range(3) != 0);
        rd = 1'($urandom);
        drive(rc, rp, re, rw, sel, rd);
        model_step(rc, rp, re, rw, sel, rd);
        tick();
        n = m_deg[sel];
        check($sformatf("rnd%0d_q", i), 16'(q), 16'((m_r >> (n - 1)) & 1));
        check($sformatf("rnd%0d_er", i), 16'(er), 16'((m_r & m_mask(n)) != 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
